// File: rtl/nibble_serial_adder.sv
// Multi-nibble add/subtract sequencer: feeds one external 4-bit adder slice per
// clock (LS nibble first), chains the carry, and returns the result with flags.
module nibble_serial_adder #(
  parameter int NIB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NIB-1:0]  op_a,
  input  logic [4*NIB-1:0]  op_b,
  input  logic              op_sub,
  output logic [3:0]        slice_a,
  output logic [3:0]        slice_b,
  output logic              slice_cin,
  input  logic [3:0]        slice_res,
  input  logic              slice_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NIB-1:0]  result,
  output logic              carry_out,
  output logic              overflow,
  output logic              zero
);
  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   cy_q, cy_d;
  logic [NIB-1:0][3:0]    a_q, a_d, b_q, b_d, res_q, res_d, res_upd;
  logic                   cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  // Current result with the in-flight nibble merged, so the zero flag sees the final word.
  always_comb begin
    res_upd         = res_q;
    res_upd[idx_q]  = slice_res;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cy_d      = cy_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b ^ {W{op_sub}};
          cy_d    = op_sub;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        slice_a   = a_q[idx_q];
        slice_b   = b_q[idx_q];
        slice_cin = cy_q;
        res_d     = res_upd;
        cy_d      = slice_cout;
        idx_d     = idx_q + 1'b1;
        if (idx_q == IW'(NIB - 1)) begin
          state_d = DONE;
          cout_d  = slice_cout;
          ovf_d   = (a_q[NIB-1][3] == b_q[NIB-1][3]) && (slice_res[3] != a_q[NIB-1][3]);
          zero_d  = (res_upd == '0);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIB=4) with a behavioural 4-bit adder slice.
module tb_nibble_serial_adder;
  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, op_sub;
  logic [W-1:0] op_a, op_b, result;
  logic [3:0]   slice_a, slice_b, slice_res;
  logic         slice_cin, slice_cout;
  logic         out_valid, out_ready, carry_out, overflow, zero;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = -1;
  bit   b2b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // External combinational adder slice
  assign {slice_cout, slice_res} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  nibble_serial_adder #(.NIB(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_res(slice_res), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t e;
    logic [W:0] s;
    if (sub) s = {1'b0, a} - {1'b0, b} + 17'h10000;
    else     s = {1'b0, a} + {1'b0, b};
    e.res = s[W-1:0];
    e.c   = s[W];
    e.v   = sub ? ((a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]))
                : ((a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]));
    e.z   = (e.res == '0);
    return e;
  endfunction

  // Output monitor: compare on every result handoff
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(result), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_flags", 32'({result, carry_out, overflow, zero}), 32'(e));
      end
    end
  end

  // Acceptance monitor: spacing of back-to-back acceptances
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready && b2b) begin
      if (last_acc >= 0) chk("b2b_accept_gap", 32'(cyc - last_acc), 32'(NIB + 2));
      last_acc = cyc;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    int n = 0;
    exp_q.push_back(e);
    op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  logic [3:0] cin_exp;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", 32'({out_valid, result, carry_out, overflow, zero}), 32'd0);
    chk("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0});
    wait_idle();

    issue(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1});
    cin_exp = 4'b1110;
    for (int k = 0; k < NIB; k++) begin
      chk($sformatf("slice_cin_%0d", k), 32'(slice_cin), 32'(cin_exp[k]));
      @(posedge clk); #1;
    end
    wait_idle();

    issue(16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0});
    wait_idle();
    issue(16'h0001, 16'h0002, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b0});
    wait_idle();

    // Stalled consumer, plus a stray request during RUN
    out_ready = 1'b0;
    issue(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0});
    in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
    for (int k = 0; k < NIB; k++) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_hold", 32'({out_valid, in_ready, result, overflow}), 32'({1'b1, 1'b0, 16'h8000, 1'b1}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset during the second RUN cycle
    issue(16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_outs", 32'({out_valid, result, carry_out, overflow, zero}), 32'd0);
    chk("midrst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h0005, 16'h0003, 1'b0, '{16'h0008, 1'b0, 1'b0, 1'b0});
    wait_idle();

    // Back-to-back random traffic with in_valid held
    b2b = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      logic s;
      int n;
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      op_a = a; op_b = b; op_sub = s;
      exp_q.push_back(model(a, b, s));
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) chk("b2b_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential multi-nibble add/subtract controller for the ALU datapath.
- Accepts full-width operands over a valid/ready handshake, then drives one 4-bit combinational ripple-adder slice per clock, least-significant nibble first.
- The external slice sits alongside: this block feeds its a/b/cin inputs and consumes its res/cout outputs in the same cycle.
- Chains the carry between cycles in a register, assembles the full-width result, and returns it with flags over a second valid/ready handshake.

Parameters:
- NIB, 4, number of 4-bit nibbles per operand; operand width W = 4*NIB; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand request.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_sub  input  1  1 = compute A-B, 0 = compute A+B.
- slice_a  output  4  nibble of A to the adder slice.
- slice_b  output  4  nibble of B (inverted when subtracting) to the adder slice.
- slice_cin  output  1  carry into the adder slice.
- slice_res  input  4  sum nibble from the adder slice (combinational).
- slice_cout  input  1  carry out from the adder slice (combinational).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum or difference, modulo 2^W.
- carry_out  output  1  final carry; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock domain (clk); rst_n is asynchronous, active-low.
- Reset values: state=IDLE, nibble index=0, carry reg=0, result=0, carry_out=0, overflow=0, zero=0, out_valid=0. in_ready=1 after reset.
- Reset mid-operation: abandons the operation, returns to reset values immediately, and emits no out_valid.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready: latch A; latch B' = op_b XOR {W{op_sub}}; latch carry reg=op_sub, index=0, sub flag; go to RUN.
- RUN: in_ready=0, out_valid=0.
  - Slice drive each cycle: slice_a=A[4*idx+3:4*idx], slice_b=B'[4*idx+3:4*idx], slice_cin=carry reg.
  - At each clock edge: result[4*idx+3:4*idx] <= slice_res; carry reg <= slice_cout; idx++.
  - When idx==NIB-1: go to DONE, carry_out <= slice_cout, overflow <= (A[W-1]==B'[W-1]) & (slice_res[3]!=A[W-1]), zero <= (assembled result==0).
- Result register: cleared on acceptance.
- Slice outputs outside RUN: slice_a=0, slice_b=0, slice_cin=0.
- DONE: out_valid=1; result and flags held stable.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
  - A new request cannot be accepted in the same cycle as result handoff; in_ready rises the cycle after.
- Latency: request accepted at edge k → out_valid high after edge k+NIB. Throughput: one operation per NIB+2 cycles with out_ready tied high.
- Handshakes: in_ready=0 in RUN and DONE. Input changes while busy are ignored. out_valid, once high, stays high with stable data until out_ready.
- Arithmetic: modulo 2^W, no saturation. Subtract uses carry chain initialised to 1.

Test Plan (NIB=4):
- ADD 0x1234 + 0x0FFF, out_ready=1 → after 4 cycles out_valid, result=0x2233, carry_out=0, overflow=0, zero=0.
- ADD 0xFFFF + 0x0001 → result=0x0000, carry_out=1, zero=1, overflow=0; slice_cin observed 0,1,1,1 across RUN cycles.
- SUB 0x8000 - 0x0001 → result=0x7FFF, carry_out=1, overflow=1; SUB 0x0001 - 0x0002 → result=0xFFFF, carry_out=0, overflow=0.
- ADD 0x7FFF + 0x0001 with out_ready low for 3 cycles → result=0x8000, overflow=1, held stable; in_ready=0 throughout; second in_valid during RUN ignored.
- Assert rst_n=0 during 2nd RUN cycle → out_valid never asserts, in_ready=1 and all outputs 0 immediately; subsequent 0x0005+0x0003 → 0x0008.
- Back-to-back requests with in_valid held high → accepts every NIB+2 cycles; results match a reference model over 1000 random operand/op_sub pairs.
